// File: rtl/iob_native_mem_responder_pkg.sv
// Shared definitions for the IOb native memory responder: FSM encoding,
// wait-counter width and packed request/response bus widths.
package iob_native_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int CNT_W = 4;

   // Request bus layout is {valid, address, wdata, wstrb} with valid at the MSB.
   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   // Response bus layout is {rdata, ready} with ready at the LSB.
   function automatic int resp_w(input int data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/iob_sp_ram_be.sv
// Single-port RAM with synchronous read and per-byte write enables.
// The output register only updates when en is high, so it holds between accesses.
module iob_sp_ram_be #(
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 10
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic [DATA_W/8-1:0]     we,
   input  logic [MEM_ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout
);

   logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

   // Read-before-write: dout gets the word as it was before this edge's write.
   always_ff @(posedge clk) begin
      if (en) begin
         dout <= mem[addr];
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/iob_native_mem_responder.sv
// IOb native bus target: byte-writable on-chip memory with a fixed number of
// wait states and a registered ready (no comb path from req valid to resp ready).
module iob_native_mem_responder
   import iob_native_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [req_w(ADDR_W, DATA_W)-1:0]   req,
   output logic [resp_w(DATA_W)-1:0]          resp,
   output logic                               busy,
   output logic                               oor
);

   localparam int REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int STRB_W = DATA_W / 8;

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;

   assign req_valid = req[REQ_W-1];
   assign req_addr  = req[REQ_W-2 -: ADDR_W];
   assign req_wdata = req[STRB_W +: DATA_W];
   assign req_wstrb = req[STRB_W-1:0];

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic              ready_q;
   logic              rdata_zero_q;
   logic              oor_q;

   // With zero wait states ACK is entered on the accepting edge itself, so the
   // RAM must see the live request fields while still in IDLE.
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [STRB_W-1:0] cur_wstrb;
   logic              in_range;
   logic              enter_ack;
   logic [DATA_W-1:0] ram_dout;

   assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cur_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;
   assign in_range  = (cur_addr[ADDR_W-2:MEM_ADDR_W+2] == '0);
   assign enter_ack = (state != ACK) && (state_nxt == ACK);

   // Region-select MSB and byte offset are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cur_addr[ADDR_W-1], cur_addr[1:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
         WAIT: if (cnt <= CNT_W'(1)) state_nxt = ACK;
         ACK:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      oor  = oor_q;
      resp = {rdata_zero_q ? {DATA_W{1'b0}} : ram_dout, ready_q};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt          <= '0;
         ready_q      <= 1'b0;
         rdata_zero_q <= 1'b1;
         oor_q        <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) cnt <= WAIT_STATES[CNT_W-1:0];
         else if (state == WAIT)         cnt <= cnt - CNT_W'(1);
         ready_q <= enter_ack;
         if (enter_ack) begin
            rdata_zero_q <= !in_range;
            if (!in_range) oor_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   iob_sp_ram_be #(
      .DATA_W     (DATA_W),
      .MEM_ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk  (clk),
      .en   (enter_ack),
      .we   ((enter_ack && in_range) ? cur_wstrb : {STRB_W{1'b0}}),
      .addr (cur_addr[MEM_ADDR_W+1:2]),
      .din  (cur_wdata),
      .dout (ram_dout)
   );

endmodule
